usr_shift_ctrl: RTL and testbench

Sequencing controller that sits directly upstream of the 8-bit universal shift register. It accepts a parallel word and direction through a valid/ready handshake, drives the register's mode selects, parallel inputs and fill inputs to load the word, and then shifts it out serially one bit per cycle. The exiting bit is presented on a serial output with downstream backpressure. The register itself is instantiated beside this block, not inside it; the controller observes the register's outputs through `sr_q`.

---
 rtl/usr_shift_ctrl_pkg.sv | 22 ++
 rtl/usr_shift_ctrl_if.sv | 45 ++++
 rtl/usr_bit_counter.sv | 28 ++
 rtl/usr_shift_ctrl.sv | 122 ++++++++++++
 tb/tb_usr_shift_ctrl.sv | 269 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/usr_shift_ctrl_pkg.sv
// Shared definitions for the universal-shift-register sequencing controller:
// register mode selects, controller state encoding and counter sizing.
package usr_ctrl_pkg;

  localparam logic [1:0] MODE_HOLD = 2'b00;
  localparam logic [1:0] MODE_SHR  = 2'b01;
  localparam logic [1:0] MODE_SHL  = 2'b10;
  localparam logic [1:0] MODE_LOAD = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_SHIFT = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  // Bits needed to hold a bit count of 0..width inclusive.
  function automatic int cnt_width(input int width);
    return $clog2(width + 1);
  endfunction

endpackage

// File: rtl/usr_shift_ctrl_if.sv
// Request, register-control and serial-output bundle of usr_shift_ctrl.
// Optional in_rot exists only when USR_SHIFT_CTRL_ROTATE_EN is defined.
interface usr_shift_ctrl_if #(parameter int WIDTH = 8);
  import usr_ctrl_pkg::*;

  localparam int CW = cnt_width(WIDTH);

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic             in_dir;
  logic [CW-1:0]    in_len;
  logic             in_fill;
`ifdef USR_SHIFT_CTRL_ROTATE_EN
  logic             in_rot;
`endif
  logic [WIDTH-1:0] sr_q;
  logic             s0;
  logic             s1;
  logic [WIDTH-1:0] par_out;
  logic             shl_in;
  logic             shr_in;
  logic             ser_out;
  logic             ser_valid;
  logic             ser_ready;
  logic             busy;
  logic             done;

  modport slave (
    input  in_valid, in_data, in_dir, in_len, in_fill, sr_q, ser_ready,
`ifdef USR_SHIFT_CTRL_ROTATE_EN
    input  in_rot,
`endif
    output in_ready, s0, s1, par_out, shl_in, shr_in, ser_out, ser_valid, busy, done
  );

  modport master (
    output in_valid, in_data, in_dir, in_len, in_fill, sr_q, ser_ready,
`ifdef USR_SHIFT_CTRL_ROTATE_EN
    output in_rot,
`endif
    input  in_ready, s0, s1, par_out, shl_in, shr_in, ser_out, ser_valid, busy, done
  );

endinterface

// File: rtl/usr_bit_counter.sv
// Loadable down-counter tracking bits remaining in a serial transfer;
// is_last flags the final bit.
module usr_bit_counter #(
  parameter int CW = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          load,
  input  logic [CW-1:0] load_val,
  input  logic          dec,
  output logic          is_last
);

  logic [CW-1:0] count_reg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_reg <= '0;
    end else if (load) begin
      count_reg <= load_val;
    end else if (dec && (count_reg != '0)) begin
      count_reg <= count_reg - 1'b1;
    end
  end

  assign is_last = (count_reg == CW'(1));

endmodule

// File: rtl/usr_shift_ctrl.sv
// Sequencer that loads a word into an external universal shift register and
// streams it out serially. USR_SHIFT_CTRL_ROTATE_EN adds the in_rot option.
module usr_shift_ctrl
  import usr_ctrl_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic              clk,
  input  logic              rst,
  usr_shift_ctrl_if.slave   bus
);

  localparam int CW = cnt_width(WIDTH);

  state_t           state_reg, state_next;
  logic [WIDTH-1:0] data_reg;
  logic             dir_reg;
  logic             fill_reg;
  logic [CW-1:0]    len_reg;
  logic             rot_reg;
  logic [CW-1:0]    len_norm;
  logic             accept;
  logic             is_last;
  logic             cnt_dec;
  logic [1:0]       mode;
  logic [WIDTH-1:0] par_out;
  logic             exit_bit;
  logic             fill_bit;

  assign accept = (state_reg == ST_IDLE) && bus.in_valid;

  // Zero and oversize lengths both mean a full-width transfer.
  always_comb begin
    len_norm = bus.in_len;
    if ((bus.in_len == '0) || (bus.in_len > CW'(WIDTH))) begin
      len_norm = CW'(WIDTH);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data_reg <= '0;
      dir_reg  <= 1'b0;
      fill_reg <= 1'b0;
      len_reg  <= '0;
      rot_reg  <= 1'b0;
    end else if (accept) begin
      data_reg <= bus.in_data;
      dir_reg  <= bus.in_dir;
      fill_reg <= bus.in_fill;
      len_reg  <= len_norm;
`ifdef USR_SHIFT_CTRL_ROTATE_EN
      rot_reg  <= bus.in_rot;
`else
      rot_reg  <= 1'b0;
`endif
    end
  end

  assign cnt_dec = (state_reg == ST_SHIFT) && bus.ser_ready;

  usr_bit_counter #(.CW(CW)) u_bit_counter (
    .clk      (clk),
    .rst      (rst),
    .load     (state_reg == ST_LOAD),
    .load_val (len_reg),
    .dec      (cnt_dec),
    .is_last  (is_last)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= ST_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    mode       = MODE_HOLD;
    par_out    = '0;
    case (state_reg)
      ST_IDLE: begin
        if (bus.in_valid) state_next = ST_LOAD;
      end
      ST_LOAD: begin
        mode       = MODE_LOAD;
        par_out    = data_reg;
        state_next = ST_SHIFT;
      end
      ST_SHIFT: begin
        // A stalled beat holds the register so ser_out cannot change.
        if (bus.ser_ready) begin
          mode = dir_reg ? MODE_SHL : MODE_SHR;
          if (is_last) state_next = ST_DONE;
        end
      end
      ST_DONE: begin
        state_next = ST_IDLE;
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  assign exit_bit = dir_reg ? bus.sr_q[WIDTH-1] : bus.sr_q[0];
  assign fill_bit = rot_reg ? exit_bit : fill_reg;

  assign bus.s0        = mode[0];
  assign bus.s1        = mode[1];
  assign bus.par_out   = par_out;
  assign bus.shl_in    = fill_bit;
  assign bus.shr_in    = fill_bit;
  assign bus.ser_out   = exit_bit;
  assign bus.ser_valid = (state_reg == ST_SHIFT);
  assign bus.in_ready  = (state_reg == ST_IDLE);
  assign bus.busy      = (state_reg != ST_IDLE);
  assign bus.done      = (state_reg == ST_DONE);

endmodule

// File: tb/tb_usr_shift_ctrl.sv
// Self-checking bench for usr_shift_ctrl with a behavioural universal shift
// register beside it; expected serial bits flow through a scoreboard queue.
module tb_usr_shift_ctrl;

  localparam int W = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  usr_shift_ctrl_if #(.WIDTH(W)) bus();

  usr_shift_ctrl #(.WIDTH(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Universal shift register model driven by the controller's mode selects.
  logic [W-1:0] sr_reg = '0;
  assign bus.sr_q = sr_reg;
  always @(posedge clk) begin
    case ({bus.s1, bus.s0})
      2'b01:   sr_reg <= {bus.shr_in, sr_reg[W-1:1]};
      2'b10:   sr_reg <= {sr_reg[W-2:0], bus.shl_in};
      2'b11:   sr_reg <= bus.par_out;
      default: sr_reg <= sr_reg;
    endcase
  end

  int   total = 0;
  int   bad   = 0;
  logic exp_q[$];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic run_xfer(input string name, input logic [W-1:0] data, input logic dir,
                          input logic [3:0] len, input logic fill, input logic rot,
                          input int pattern, input logic hold_next,
                          input logic [W-1:0] n_data, input logic n_dir, input logic [3:0] n_len,
                          input logic n_fill, input logic [W-1:0] exp_final);
    int   nlen;
    int   cyc;
    int   stalls;
    int   shifts;
    int   k;
    logic rdy;
    logic got_done;
    logic exp_bit;
    logic [W-1:0] final_sr;

    bus.in_valid = 1'b1;
    bus.in_data  = data;
    bus.in_dir   = dir;
    bus.in_len   = len;
    bus.in_fill  = fill;
`ifdef USR_SHIFT_CTRL_ROTATE_EN
    bus.in_rot   = rot;
`endif
    bus.ser_ready = 1'b1;
    #1;
    total++;
    if (bus.in_ready !== 1'b1) begin
      bad++;
      $display("FAIL %s accept_ready: got %b want 1", name, bus.in_ready);
    end
    nlen = ((len == 0) || (len > W)) ? W : int'(len);
    for (int i = 0; i < nlen; i++) begin
      exp_q.push_back(dir ? data[W-1-i] : data[i]);
    end

    step();
    if (hold_next) begin
      bus.in_data = n_data;
      bus.in_dir  = n_dir;
      bus.in_len  = n_len;
      bus.in_fill = n_fill;
    end else begin
      bus.in_valid = 1'b0;
    end
    #1;
    total++;
    if ({bus.s1, bus.s0} !== 2'b11 || bus.par_out !== data || bus.ser_valid !== 1'b0) begin
      bad++;
      $display("FAIL %s load: mode=%b par_out=%h ser_valid=%b want mode=11 par_out=%h ser_valid=0",
               name, {bus.s1, bus.s0}, bus.par_out, bus.ser_valid, data);
    end

    cyc = 1; stalls = 0; shifts = 0; got_done = 1'b0;
    while (!got_done && cyc < 100) begin
      step();
      cyc++;
      k   = cyc - 2;
      rdy = (pattern == 0) ? 1'b1 : ((k % 4 == 0) || (k % 4 == 3));
      bus.ser_ready = rdy;
      #1;
      if (bus.done === 1'b1) begin
        got_done = 1'b1;
        total++;
        if (cyc != 2 + nlen + stalls || exp_q.size() != 0 || bus.ser_valid !== 1'b0) begin
          bad++;
          $display("FAIL %s done_cycle: got A+%0d left=%0d ser_valid=%b want A+%0d left=0 ser_valid=0",
                   name, cyc, exp_q.size(), bus.ser_valid, 2 + nlen + stalls);
        end
      end else begin
        total++;
        if (bus.ser_valid !== 1'b1 || bus.in_ready !== 1'b0) begin
          bad++;
          $display("FAIL %s shift_state: ser_valid=%b in_ready=%b at A+%0d want 1/0",
                   name, bus.ser_valid, bus.in_ready, cyc);
        end
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL %s extra_bit: got ser_out=%b at A+%0d want done", name, bus.ser_out, cyc);
        end else if (rdy) begin
          exp_bit = exp_q.pop_front();
          shifts++;
          total++;
          if (bus.ser_out !== exp_bit || {bus.s1, bus.s0} !== (dir ? 2'b10 : 2'b01)) begin
            bad++;
            $display("FAIL %s shift_bit%0d: ser_out=%b mode=%b want ser_out=%b mode=%b",
                     name, shifts - 1, bus.ser_out, {bus.s1, bus.s0}, exp_bit, dir ? 2'b10 : 2'b01);
          end
        end else begin
          stalls++;
          total++;
          if (bus.ser_out !== exp_q[0] || {bus.s1, bus.s0} !== 2'b00) begin
            bad++;
            $display("FAIL %s stall: ser_out=%b mode=%b want ser_out=%b mode=00",
                     name, bus.ser_out, {bus.s1, bus.s0}, exp_q[0]);
          end
        end
      end
    end
    if (!got_done) begin
      total++;
      bad++;
      $display("FAIL %s done_timeout: got no done after %0d cycles want done", name, cyc);
    end
    final_sr = sr_reg;
    total++;
    if (final_sr !== exp_final || shifts != nlen) begin
      bad++;
      $display("FAIL %s final: sr=%h shifts=%0d want sr=%h shifts=%0d",
               name, final_sr, shifts, exp_final, nlen);
    end
    bus.ser_ready = 1'b1;
    step();
    #1;
    total++;
    if (bus.in_ready !== 1'b1 || bus.busy !== 1'b0) begin
      bad++;
      $display("FAIL %s ready_again: in_ready=%b busy=%b want 1/0", name, bus.in_ready, bus.busy);
    end
    exp_q.delete();
    $display("xfer %s data=%h dir=%b len=%0d fill=%b rot=%b stalls=%0d cycles=%0d sr=%h",
             name, data, dir, nlen, fill, rot, stalls, cyc, final_sr);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    step();
    step();
    total++;
    if (bus.in_ready !== 1'b1 || {bus.s1, bus.s0} !== 2'b00 || bus.ser_valid !== 1'b0 ||
        bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.par_out !== '0) begin
      bad++;
      $display("FAIL reset: in_ready=%b mode=%b ser_valid=%b busy=%b done=%b par_out=%h want 1/00/0/0/0/00",
               bus.in_ready, {bus.s1, bus.s0}, bus.ser_valid, bus.busy, bus.done, bus.par_out);
    end
    rst = 1'b0;
    step();
    total++;
    if (bus.in_ready !== 1'b1 || bus.busy !== 1'b0) begin
      bad++;
      $display("FAIL idle: in_ready=%b busy=%b want 1/0", bus.in_ready, bus.busy);
    end
    $display("reset checked");
  endtask

  task automatic test_reset_mid();
    bus.in_valid = 1'b1;
    bus.in_data  = 8'hFF;
    bus.in_dir   = 1'b0;
    bus.in_len   = 4'd8;
    bus.in_fill  = 1'b0;
    bus.ser_ready = 1'b1;
    step();
    bus.in_valid = 1'b0;
    step();
    step();
    total++;
    if (bus.ser_valid !== 1'b1) begin
      bad++;
      $display("FAIL mid_pre: ser_valid=%b want 1", bus.ser_valid);
    end
    rst = 1'b1;
    #1;
    total++;
    if (bus.in_ready !== 1'b1 || {bus.s1, bus.s0} !== 2'b00 || bus.ser_valid !== 1'b0 ||
        bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.par_out !== '0) begin
      bad++;
      $display("FAIL mid_reset: in_ready=%b mode=%b ser_valid=%b busy=%b done=%b par_out=%h want 1/00/0/0/0/00",
               bus.in_ready, {bus.s1, bus.s0}, bus.ser_valid, bus.busy, bus.done, bus.par_out);
    end
    step();
    rst = 1'b0;
    step();
    $display("xfer mid_reset abandoned sr=%h", sr_reg);
  endtask

  task automatic test_right_full();
    run_xfer("right_full", 8'hA5, 1'b0, 4'd0, 1'b0, 1'b0, 0, 1'b0, '0, 1'b0, 4'd0, 1'b0, 8'h00);
  endtask

  task automatic test_left_partial();
    run_xfer("left_partial", 8'h3C, 1'b1, 4'd3, 1'b1, 1'b0, 0, 1'b0, '0, 1'b0, 4'd0, 1'b0, 8'hE7);
  endtask

  task automatic test_saturate();
    run_xfer("len_sat", 8'h96, 1'b1, 4'd13, 1'b0, 1'b0, 0, 1'b0, '0, 1'b0, 4'd0, 1'b0, 8'h00);
  endtask

  task automatic test_backpressure();
    run_xfer("backpressure", 8'h81, 1'b0, 4'd8, 1'b1, 1'b0, 1, 1'b0, '0, 1'b0, 4'd0, 1'b0, 8'hFF);
  endtask

  task automatic test_back_to_back();
    run_xfer("b2b_first", 8'h5A, 1'b1, 4'd4, 1'b0, 1'b0, 0, 1'b1, 8'hC3, 1'b0, 4'd2, 1'b1, 8'hA0);
    run_xfer("b2b_second", 8'hC3, 1'b0, 4'd2, 1'b1, 1'b0, 0, 1'b0, '0, 1'b0, 4'd0, 1'b0, 8'hF0);
  endtask

`ifdef USR_SHIFT_CTRL_ROTATE_EN
  task automatic test_rotate();
    run_xfer("rotate", 8'h01, 1'b1, 4'd8, 1'b0, 1'b1, 0, 1'b0, '0, 1'b0, 4'd0, 1'b0, 8'h01);
    bus.in_rot = 1'b0;
  endtask
`endif

  initial begin
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.in_dir    = 1'b0;
    bus.in_len    = '0;
    bus.in_fill   = 1'b0;
    bus.ser_ready = 1'b1;
`ifdef USR_SHIFT_CTRL_ROTATE_EN
    bus.in_rot    = 1'b0;
`endif
    test_reset();
    test_right_full();
    test_left_partial();
    test_saturate();
    test_backpressure();
    test_back_to_back();
    test_reset_mid();
`ifdef USR_SHIFT_CTRL_ROTATE_EN
    test_rotate();
`endif
    test_right_full();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
